// File: rtl/vend_pkg.sv
// Shared vending datapath types: coin codes and the coin acceptor state encoding.
// vending_machine_p2 decodes the same coin constants.
package vend_pkg;

   typedef logic [1:0] coin_t;

   localparam coin_t COIN_NONE = 2'b00;
   localparam coin_t COIN_HALF = 2'b01;
   localparam coin_t COIN_ONE  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      HIGH,
      GAP,
      EMIT,
      JAM
   } acc_state_t;

   // One pulse is half a unit, two pulses a full unit; anything else is refused.
   function automatic coin_t decode_coin(input logic [1:0] pcnt, input logic frame_ok);
      if (!frame_ok) return COIN_NONE;
      case (pcnt)
         2'd1:    return COIN_HALF;
         2'd2:    return COIN_ONE;
         default: return COIN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus counter debouncer with single-cycle edge strobes.
// The strobes fire in the same cycle the debounced level first shows its new value.
module sync_debounce #(
   parameter int DEB_CYC = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

   logic          sync_q1;
   logic          sync;
   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q1 <= 1'b0;
         sync    <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         sync_q1 <= din;
         sync    <= sync_q1;
         rise    <= 1'b0;
         fall    <= 1'b0;
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync;
            rise  <= sync;
            fall  <= ~sync;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: turns the bouncy coin-mechanism pulse train into a
// one-cycle coin code, refusing malformed frames, jams and disabled insertions.
module coin_acceptor
   import vend_pkg::*;
#(
   parameter int DEB_CYC  = 4,
   parameter int GAP_CYC  = 20,
   parameter int HIGH_MAX = 64
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic       pulse_in,
   output logic [1:0] coin,
   output logic       reject,
   output logic       busy
);

   localparam int HW = (HIGH_MAX > 1) ? $clog2(HIGH_MAX) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [HW-1:0] HCNT_LAST = HW'(HIGH_MAX - 1);
   localparam logic [GW-1:0] GCNT_LAST = GW'(GAP_CYC - 1);

   logic db, rise, fall;

   sync_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_sync_debounce (
      .clk   (clk),
      .rstn  (rstn),
      .din   (pulse_in),
      .level (db),
      .rise  (rise),
      .fall  (fall)
   );

   acc_state_t    state, state_d;
   logic [1:0]    pcnt, pcnt_d;
   logic          frame_ok, frame_ok_d;
   logic [HW-1:0] hcnt, hcnt_d;
   logic [GW-1:0] gcnt, gcnt_d;
   coin_t         coin_d;
   logic          reject_d;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state;
      pcnt_d     = pcnt;
      frame_ok_d = frame_ok;
      hcnt_d     = hcnt;
      gcnt_d     = gcnt;
      coin_d     = COIN_NONE;
      reject_d   = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_d    = HIGH;
               pcnt_d     = 2'd1;
               frame_ok_d = en;
               hcnt_d     = '0;
            end
         end
         HIGH: begin
            frame_ok_d = frame_ok & en;
            if (fall) begin
               state_d = GAP;
               gcnt_d  = '0;
            end else if (hcnt == HCNT_LAST) begin
               state_d  = JAM;
               reject_d = 1'b1;
            end else begin
               hcnt_d = hcnt + 1'b1;
            end
         end
         GAP: begin
            frame_ok_d = frame_ok & en;
            if (rise) begin
               state_d = HIGH;
               hcnt_d  = '0;
               if (pcnt != 2'd3) pcnt_d = pcnt + 1'b1;
            end else if (gcnt == GCNT_LAST) begin
               // Outputs are registered on the way into EMIT so they line up with it.
               state_d  = EMIT;
               coin_d   = decode_coin(pcnt, frame_ok_d);
               reject_d = (coin_d == COIN_NONE);
            end else begin
               gcnt_d = gcnt + 1'b1;
            end
         end
         EMIT: state_d = IDLE;
         JAM: begin
            if (fall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         pcnt     <= '0;
         frame_ok <= 1'b0;
         hcnt     <= '0;
         gcnt     <= '0;
         coin     <= COIN_NONE;
         reject   <= 1'b0;
      end else begin
         state    <= state_d;
         pcnt     <= pcnt_d;
         frame_ok <= frame_ok_d;
         hcnt     <= hcnt_d;
         gcnt     <= gcnt_d;
         coin     <= coin_d;
         reject   <= reject_d;
      end
   end

   assign busy = (state != IDLE);

endmodule
